// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO-producing multiply/divide unit.
// Accumulate ops (1xx) are legal only when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam int MDU_DATA_W = 32;

  // Operation codes as presented by the EX stage
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIX   = 2'b10,
    WRITE = 2'b11
  } mdu_state_e;

  // LO value written by any divide with a zero divisor (wide enough for any DATA_W up to 64)
  localparam logic [63:0] DIV_ZERO_LO = 64'hFFFF_FFFF_FFFF_FFFF;

  // Even parity of a 64-bit word, shared by blocks that protect HI/LO data
  function automatic logic parity64(input logic [63:0] word);
    parity64 = ^word;
  endfunction

endpackage

// File: rtl/mdu_hilo_writer_if.sv
// EX-stage <-> multiply/divide unit interface, including the HI/LO write port.
// master = EX stage / HI-LO side, slave = the MDU.
interface mdu_hilo_writer_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] hi_cur;
  logic [DATA_W-1:0] lo_cur;
  logic              flush;
  logic              busy;
  logic              hilo_en;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output start, op, opa, opb, hi_cur, lo_cur, flush,
    input  busy, hilo_en, hi_out, lo_out
  );

  modport slave (
    input  start, op, opa, opb, hi_cur, lo_cur, flush,
    output busy, hilo_en, hi_out, lo_out
  );
endinterface

// File: rtl/mdu_iter_core.sv
// One iteration of the MDU datapath: a radix-2 shift-add step (multiply)
// or a restoring trial-subtract step (divide). Purely combinational.
// Register pair {up, low}: multiply = {partial hi, remaining multiplier},
// divide = {partial remainder, dividend bits / quotient bits}.
module mdu_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic              div_mode,
  input  logic [DATA_W-1:0] up,
  input  logic [DATA_W-1:0] low,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] up_nxt,
  output logic [DATA_W-1:0] low_nxt
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] shifted_s;
  logic [DATA_W:0] diff_s;
  logic            fits_s;

  // Single shift-add or trial-subtract step selected by div_mode
  always_comb begin
    sum_s     = {1'b0, up} + (low[0] ? {1'b0, b} : {(DATA_W+1){1'b0}});
    shifted_s = {up, low[DATA_W-1]};
    diff_s    = shifted_s - {1'b0, b};
    fits_s    = ~diff_s[DATA_W];
    up_nxt    = '0;
    low_nxt   = '0;
    if (div_mode) begin
      // Restore (keep the shifted value) when the trial subtraction borrows
      up_nxt  = fits_s ? diff_s[DATA_W-1:0] : shifted_s[DATA_W-1:0];
      low_nxt = {low[DATA_W-2:0], fits_s};
    end else begin
      // Add multiplicand on a set multiplier bit, then shift the pair right
      up_nxt  = sum_s[DATA_W:1];
      low_nxt = {sum_s[0], low[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mdu_hilo_writer.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing its 64-bit result to HI/LO with
// a single-cycle strobe. Latency: accept (cycle 0), CALC x DATA_W, FIX, WRITE.
// Optional macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (accumulate into
// the HI/LO value captured at accept); without it, ops 1xx are refused.
module mdu_hilo_writer
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input logic               clk,
  input logic               rst,
  mdu_hilo_writer_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W);

  mdu_state_e        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              busy_r;
  logic              hilo_en_r;
  logic [DATA_W-1:0] hi_out_r;
  logic [DATA_W-1:0] lo_out_r;
  logic [DATA_W-1:0] up_r;
  logic [DATA_W-1:0] low_r;
  logic [DATA_W-1:0] b_r;
  logic              div_r;
  logic              sign_q_r;
  logic              sign_rem_r;

  logic              legal_s;
  logic              is_div_s;
  logic              is_signed_s;
  logic              sa_s;
  logic              sb_s;
  logic [DATA_W-1:0] abs_a_s;
  logic [DATA_W-1:0] abs_b_s;
  logic [DATA_W-1:0] up_nxt_s;
  logic [DATA_W-1:0] low_nxt_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_fix_s;
  logic [2*DATA_W-1:0] mul_res_s;
  logic [DATA_W-1:0] quo_fix_s;
  logic [DATA_W-1:0] rem_fix_s;
  logic [DATA_W-1:0] fix_hi_s;
  logic [DATA_W-1:0] fix_lo_s;

`ifdef MDU_MADD_EN
  logic              acc_r;
  logic              sub_r;
  logic [DATA_W-1:0] hi_cur_r;
  logic [DATA_W-1:0] lo_cur_r;
`else
  logic [2*DATA_W-1:0] unused_cur_s;
  assign unused_cur_s = {bus.hi_cur, bus.lo_cur};
`endif

  // Operand decode and magnitude extraction for the accept cycle
  always_comb begin
`ifdef MDU_MADD_EN
    legal_s = 1'b1;
`else
    legal_s = ~bus.op[2];
`endif
    is_div_s    = (bus.op[2:1] == 2'b01);
    is_signed_s = ~bus.op[0];
    sa_s        = is_signed_s & bus.opa[DATA_W-1];
    sb_s        = is_signed_s & bus.opb[DATA_W-1];
    abs_a_s     = sa_s ? -bus.opa : bus.opa;
    abs_b_s     = sb_s ? -bus.opb : bus.opb;
  end

  mdu_iter_core #(.DATA_W(DATA_W)) u_iter (
    .div_mode (div_r),
    .up       (up_r),
    .low      (low_r),
    .b        (b_r),
    .up_nxt   (up_nxt_s),
    .low_nxt  (low_nxt_s)
  );

  // Sign correction, accumulate and divide-by-zero override applied in FIX
  always_comb begin
    prod_s     = {up_r, low_r};
    prod_fix_s = sign_q_r ? -prod_s : prod_s;
`ifdef MDU_MADD_EN
    if (acc_r) begin
      if (sub_r) begin
        mul_res_s = {hi_cur_r, lo_cur_r} - prod_fix_s;
      end else begin
        mul_res_s = {hi_cur_r, lo_cur_r} + prod_fix_s;
      end
    end else begin
      mul_res_s = prod_fix_s;
    end
`else
    mul_res_s = prod_fix_s;
`endif
    quo_fix_s = sign_q_r ? -low_r : low_r;
    rem_fix_s = sign_rem_r ? -up_r : up_r;
    if (div_r) begin
      // Zero divisor: the remainder path already reproduces opa
      fix_hi_s = rem_fix_s;
      fix_lo_s = (b_r == '0) ? DIV_ZERO_LO[DATA_W-1:0] : quo_fix_s;
    end else begin
      fix_hi_s = mul_res_s[2*DATA_W-1:DATA_W];
      fix_lo_s = mul_res_s[DATA_W-1:0];
    end
  end

  // Sequencer, iteration registers and registered HI/LO write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      busy_r     <= 1'b0;
      hilo_en_r  <= 1'b0;
      hi_out_r   <= '0;
      lo_out_r   <= '0;
      up_r       <= '0;
      low_r      <= '0;
      b_r        <= '0;
      div_r      <= 1'b0;
      sign_q_r   <= 1'b0;
      sign_rem_r <= 1'b0;
`ifdef MDU_MADD_EN
      acc_r      <= 1'b0;
      sub_r      <= 1'b0;
      hi_cur_r   <= '0;
      lo_cur_r   <= '0;
`endif
    end else if (bus.flush && (state_r != IDLE)) begin
      // Abort: outputs keep their last written value, no strobe
      state_r   <= IDLE;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      hilo_en_r <= 1'b0;
    end else begin
      hilo_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start && !bus.flush && legal_s) begin
            state_r    <= CALC;
            busy_r     <= 1'b1;
            cnt_r      <= '0;
            div_r      <= is_div_s;
            sign_q_r   <= sa_s ^ sb_s;
            sign_rem_r <= sa_s;
            up_r       <= '0;
            low_r      <= is_div_s ? abs_a_s : abs_b_s;
            b_r        <= is_div_s ? abs_b_s : abs_a_s;
`ifdef MDU_MADD_EN
            acc_r      <= bus.op[2];
            sub_r      <= bus.op[1];
            hi_cur_r   <= bus.hi_cur;
            lo_cur_r   <= bus.lo_cur;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          up_r  <= up_nxt_s;
          low_r <= low_nxt_s;
          if (cnt_r == CNT_W'(DATA_W - 1)) begin
            cnt_r   <= '0;
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        FIX: begin
          hi_out_r  <= fix_hi_s;
          lo_out_r  <= fix_lo_s;
          hilo_en_r <= 1'b1;
          state_r   <= WRITE;
        end
        WRITE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.hilo_en = hilo_en_r;
  assign bus.hi_out  = hi_out_r;
  assign bus.lo_out  = lo_out_r;

endmodule
